// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: counts core run cycles, enforces a cycle budget,
// snapshots the register file at end of run and streams a
// NREG+2 word result record over valid/ready.
//
// Ports:
//   clk, rst       - clock, async active-high reset
//   completed      - core end-of-program level
//   registers      - flattened register file, r[i] at [32i+31:32i]
//   out_valid/out_ready/out_data/out_last - record stream
//   busy           - high while running or streaming
//   done           - record fully transferred (sticky)
//   timeout        - run ended by budget (sticky)
module cpu_run_monitor #(
    parameter int MAX_CLOCKS = 100000,
    parameter int CNT_W      = 32,
    parameter int NREG       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              completed,
    input  logic [32*NREG-1:0] registers,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam int IDX_W = $clog2(NREG + 2);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG + 1);
    localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(MAX_CLOCKS - 1);
    localparam logic [CNT_W-1:0] BUDGET_CNT  = CNT_W'(MAX_CLOCKS);

    logic [1:0]       state_q, state_d;
    // cnt_q counts RUN cycles and then doubles as the captured count
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             timeout_q, timeout_d;
    logic             comp_q, comp_d;
    logic [31:0]      snap_q [NREG];
    logic [31:0]      snap_d [NREG];
    logic [31:0]      word;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        timeout_d = timeout_q;
        comp_d    = comp_q;
        snap_d    = snap_q;
        unique case (state_q)
            S_RUN: begin
                if (completed || cnt_q == BUDGET_LAST) begin
                    for (int i = 0; i < NREG; i++) begin
                        snap_d[i] = registers[32*i +: 32];
                    end
                    state_d = S_STREAM;
                    // completion wins over a simultaneous budget hit
                    comp_d    = completed;
                    timeout_d = !completed;
                    if (!completed) begin
                        cnt_d = BUDGET_CNT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            idx_q     <= '0;
            timeout_q <= 1'b0;
            comp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
            comp_q    <= comp_d;
        end
    end

    // Snapshot contents are meaningless until captured, so no reset
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    always_comb begin
        word = '0;
        if (idx_q == '0) begin
            word = 32'(cnt_q);
        end else if (idx_q == IDX_W'(1)) begin
            word = {30'd0, comp_q, timeout_q};
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (idx_q == IDX_W'(i + 2)) begin
                    word = snap_q[i];
                end
            end
        end
    end

    assign out_valid = (state_q == S_STREAM);
    assign out_data  = out_valid ? word : 32'd0;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign busy      = (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: directed bench for cpu_run_monitor with a
// scoreboard queue of expected record words.
module tb_cpu_run_monitor;

    localparam int NREG = 32;
    localparam int MAXC = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              completed = 1'b0;
    logic [32*NREG-1:0] registers = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              timeout;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] regs_m [NREG];

    cpu_run_monitor #(
        .MAX_CLOCKS(MAXC),
        .CNT_W(32),
        .NREG(NREG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .completed(completed),
        .registers(registers),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .done(done),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_regs();
        for (int i = 0; i < NREG; i++) begin
            registers[32*i +: 32] = regs_m[i];
        end
    endtask

    task automatic push_record(input logic [31:0] cnt,
                               input logic [31:0] status);
        exp_q.push_back(cnt);
        exp_q.push_back(status);
        for (int i = 0; i < NREG; i++) begin
            exp_q.push_back(regs_m[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        completed = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 1);
        rst = 1'b0;
    endtask

    // n_idle RUN edges with completed low, then optionally one
    // edge with completed high; returns at the negedge after capture
    task automatic run_to_capture(input int n_idle, input bit fire);
        completed = 1'b0;
        repeat (n_idle) @(negedge clk);
        if (fire) begin
            completed = 1'b1;
            @(negedge clk);
            completed = 1'b0;
        end
    endtask

    // mode 0: ready always, 1: ready 1,0,0 pattern, 2: random
    task automatic drain(input int mode, input int max_x,
                         input int budget, output int cycles);
        int xfers;
        bit last_e;
        cycles = 0;
        xfers = 0;
        while (exp_q.size() > 0 && xfers < max_x && cycles < budget) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (cycles % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            check("valid", out_valid, 1);
            last_e = (exp_q.size() == 1);
            if (out_ready) begin
                check("data", out_data, exp_q.pop_front());
                check("last", out_last, 32'(last_e));
                xfers++;
            end else begin
                check("stall_data", out_data, exp_q[0]);
                check("stall_last", out_last, 32'(last_e));
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NREG; i++) begin
                registers[32*i +: 32] = $urandom;
            end
            completed = 1'($urandom_range(0, 1));
            @(negedge clk);
            cycles++;
        end
        completed = 1'b0;
        out_ready = 1'b0;
        check("drain_budget", 32'(cycles < budget), 1);
    endtask

    task automatic check_done(input logic exp_to);
        check("done", done, 1);
        check("done_valid", out_valid, 0);
        check("done_last", out_last, 0);
        check("done_busy", busy, 0);
        check("done_timeout", timeout, 32'(exp_to));
    endtask

    initial begin
        int cyc;

        for (int i = 0; i < NREG; i++) begin
            regs_m[i] = 32'hC0DE_0000 | 32'(i);
        end
        regs_m[0]  = 32'h0;
        regs_m[1]  = 32'd5;
        regs_m[2]  = 32'hFFFF_FFFD;
        regs_m[31] = 32'h1234_5678;

        // completed after 7 cycles, ready held high
        load_regs();
        do_reset();
        push_record(32'd7, 32'h2);
        run_to_capture(7, 1'b1);
        check("cap_timeout", timeout, 0);
        check("cap_done", done, 0);
        drain(0, 100, 200, cyc);
        check("b2b_cycles", cyc, 34);
        check_done(1'b0);

        // same run with ready stalls
        load_regs();
        do_reset();
        push_record(32'd7, 32'h2);
        run_to_capture(7, 1'b1);
        drain(1, 100, 300, cyc);
        check("stall_cycles", cyc, 100);
        check_done(1'b0);

        // budget exhausted, completed never asserted
        for (int i = 0; i < NREG; i++) regs_m[i] = $urandom;
        load_regs();
        do_reset();
        push_record(32'd20, 32'h1);
        run_to_capture(MAXC, 1'b0);
        check("to_timeout", timeout, 1);
        check("to_busy", busy, 1);
        drain(2, 100, 400, cyc);
        check_done(1'b1);

        // completed on the budget edge wins
        for (int i = 0; i < NREG; i++) regs_m[i] = $urandom;
        load_regs();
        do_reset();
        push_record(32'd19, 32'h2);
        run_to_capture(MAXC - 1, 1'b1);
        check("edge_timeout", timeout, 0);
        drain(0, 100, 200, cyc);
        check_done(1'b0);

        // completed re-asserted in DONE has no effect
        completed = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_done(1'b0);
            check("done_data", out_data, 0);
        end
        completed = 1'b0;

        // async reset in the middle of the record
        for (int i = 0; i < NREG; i++) regs_m[i] = $urandom;
        load_regs();
        do_reset();
        push_record(32'd4, 32'h2);
        run_to_capture(4, 1'b1);
        drain(0, 10, 100, cyc);
        check("mid_word10", out_data, exp_q[0]);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_done", done, 0);
        check("arst_busy", busy, 1);
        check("arst_timeout", timeout, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NREG; i++) regs_m[i] = $urandom;
        load_regs();
        push_record(32'd3, 32'h2);
        run_to_capture(3, 1'b1);
        drain(0, 100, 200, cyc);
        check("rerun_cycles", cyc, 34);
        check_done(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
Synthesizable run monitor sitting directly downstream of the cpu core. It consumes the core's `completed` flag and architectural register file. It counts execution cycles, enforces a cycle budget, snapshots the registers at end of run, and streams a fixed 34-word result record over a valid/ready interface to a host/UART/log sink. It replaces bench-only cycle counting and register dumping with hardware usable on FPGA.

Parameters:
- MAX_CLOCKS, 100000, cycle budget; reaching it without completion ends the run with the timeout flag set.
- CNT_W, 32, cycle counter width; must satisfy 2^CNT_W > MAX_CLOCKS.
- NREG, 32, number of architectural registers snapshotted (record length = NREG+2).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- completed, input, 1, cpu end-of-program flag (level, sampled each edge).
- registers, input, 32*NREG, flattened cpu register file; r[i] occupies bits [32i+31:32i].
- out_valid, output, 1, record word valid.
- out_ready, input, 1, sink accepts word.
- out_data, output, 32, record word.
- out_last, output, 1, high with the final record word.
- busy, output, 1, high in RUN or STREAM.
- done, output, 1, record fully transferred; sticky until rst.
- timeout, output, 1, run ended by budget rather than completed; sticky until rst.

Behaviour:
- Reset (async assert, any state): state=RUN, cycle_cnt=0, word_idx=0, out_valid=0, out_data=0, out_last=0, done=0, timeout=0, busy=1 (busy decodes from state). Snapshot contents are don't-care. Reset mid-STREAM aborts the record with no partial-record recovery.
- States: RUN, STREAM, DONE.
- RUN, each edge:
  - completed=1: capture cycle_cnt, timeout=0, registers into snapshot; go to STREAM.
  - Else if cycle_cnt==MAX_CLOCKS-1: capture MAX_CLOCKS as count, timeout=1, snapshot registers; go to STREAM.
  - Else cycle_cnt+1.
  - Simultaneous completed and budget hit: completed wins, timeout=0.
  - Count semantics: number of RUN edges with completed=0 before the capturing edge. completed high at first edge after reset gives count 0.
- Snapshot is frozen at the capture edge. Later changes on registers or completed have no effect.
- STREAM:
  - out_valid=1 from the first cycle after capture. Latency from the capture edge to first valid is 1 cycle.
  - Word order, word_idx 0..NREG+1:
    - 0 = captured count, zero-extended to 32 bits.
    - 1 = status: bit0=timeout, bit1=1 (completed path) or 0, bits[31:2]=0.
    - 2..NREG+1 = r0..r(NREG-1), raw two's-complement bits.
  - Transfer occurs on an edge with out_valid&&out_ready; word_idx then increments.
  - While out_valid&&!out_ready, out_data, out_last and word_idx hold stable.
  - out_last=1 exactly when word_idx==NREG+1.
  - Back-to-back transfers every cycle with out_ready held high: the record takes NREG+2 cycles.
- Transfer of the last word: go to DONE. That edge out_valid=0, out_last=0, done=1.
- DONE: terminal until rst. busy=0, out_valid=0, completed ignored.
- timeout is visible from the capture edge onward; done rises only after the last transfer.

Test Plan:
- Completed after 7 cycles, with r1=5, r2=-3, r31=0x12345678, out_ready=1: words are 7, 0x2, 0, 5, 0xFFFFFFFD, …, 0x12345678. out_last only on word 33. done=1 one edge after word 33. Total 34 consecutive valid cycles.
- Same run with out_ready toggling 1,0,0,1…: out_data/out_last hold during stalls. Sequence is identical, no word duplicated or dropped.
- MAX_CLOCKS=20, completed never asserted: word0=20, word1=0x1, timeout=1, done after 34 transfers.
- MAX_CLOCKS=20, completed rising exactly at the edge where cycle_cnt=19: word0=19, word1=0x2, timeout=0.
- Registers changed every cycle after capture, completed deasserted: streamed values equal capture-edge values. completed re-asserting in DONE leaves all outputs unchanged.
- rst asserted mid-STREAM at word 10: out_valid=0 and done=0 immediately (async). After release the monitor counts from 0 and a new full 34-word record follows.
